mcu_sequencer: RTL

MCU_SEQUENCER -- requirements
Module: mcu_sequencer

---
 rtl/mcu_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mcu_sequencer.sv
// Issue/launch/wait/complete sequencer for four multi-cycle arithmetic units.
// A unit completes only after its ready level has dropped and risen again, or the op times out.
module mcu_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [1:0]  unit_sel,
  input  logic        sub_in,
  input  logic [3:0]  ready,
  input  logic [31:0] u0_out1,
  input  logic [31:0] u0_out2,
  input  logic [31:0] u1_out1,
  input  logic [31:0] u1_out2,
  input  logic [31:0] u2_out,
  input  logic [31:0] u3_out,
  input  logic        err_clr,
  output logic [3:0]  exe,
  output logic        sub_out,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          sub_q, sub_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   out1_q, out1_d;
  logic [31:0]   out2_q, out2_d;

  logic          sel_ready;
  logic          complete;
  logic [31:0]   res1, res2;

  assign sel_ready = ready[sel_q];
  // armed_q proves the selected unit dropped ready during this op, so a stale high level is rejected.
  assign complete  = (state_q == S_WAIT) && armed_q && sel_ready;

  always_comb begin
    res1 = '0;
    res2 = '0;
    case (sel_q)
      2'd0:    begin res1 = u0_out1; res2 = u0_out2; end
      2'd1:    begin res1 = u1_out1; res2 = u1_out2; end
      2'd2:    res1 = u2_out;
      default: res1 = u3_out;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d = state_q;
    sel_d   = sel_q;
    sub_d   = sub_q;
    armed_d = armed_q;
    wcnt_d  = wcnt_q;
    out1_d  = out1_q;
    out2_d  = out2_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (issue) begin
          sel_d   = unit_sel;
          sub_d   = sub_in;
          armed_d = 1'b0;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        armed_d = armed_q | ~sel_ready;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (complete) begin
          out1_d  = res1;
          out2_d  = res2;
          state_d = S_DONE;
        end else begin
          armed_d = armed_q | ~sel_ready;
          if (wcnt_q == LAST_WAIT) begin
            state_d = S_ERR;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_ERR: begin
        if (err_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      sub_q   <= 1'b0;
      armed_q <= 1'b0;
      wcnt_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sub_q   <= sub_d;
      armed_q <= armed_d;
      wcnt_q  <= wcnt_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  assign exe     = (state_q == S_LAUNCH) ? (4'b0001 << sel_q) : 4'b0000;
  assign sub_out = sub_q;
  assign out1    = out1_q;
  assign out2    = out2_q;
  assign busy    = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign done    = (state_q == S_DONE);
  assign err     = (state_q == S_ERR);

endmodule
